// File: rtl/exhaustive_stim_seq.sv
// Exhaustive stimulus sequencer: walks every IN_W-bit input vector in ascending order,
// samples the DUT response on the last hold cycle of each vector and folds it into a MISR.
module exhaustive_stim_seq #(
    parameter int                IN_W        = 5,
    parameter int                OUT_W       = 6,
    parameter int                HOLD        = 1,
    parameter int                REPEAT_LAST = 1,
    parameter int                SIG_W       = 16,
    parameter logic [SIG_W-1:0]  POLY        = SIG_W'(16'h1021)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OUT_W-1:0]  resp,
    output logic [IN_W-1:0]   stim,
    output logic              stim_valid,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  sig,
    output logic [IN_W:0]     vec_count
);

    localparam int               HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);
    localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
    localparam logic [IN_W-1:0]  STIM_LAST = '1;
    localparam logic [IN_W-1:0]  STIM_ONE  = IN_W'(1);
    localparam logic [IN_W:0]    VC_ONE    = (IN_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [HW-1:0]     hold_cnt, hold_n;
    logic [IN_W-1:0]   stim_n;
    logic [SIG_W-1:0]  sig_n;
    logic [IN_W:0]     vc_n;
    logic              rep_flag, rep_n;
    logic [1:0]        rst_pipe;
    logic              run_ok;
    logic [SIG_W-1:0]  resp_ext;
    logic [SIG_W-1:0]  misr_next;

    // Reset release is re-timed to clk; starts are refused until it has propagated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign run_ok = rst_pipe[1];

    always_comb begin
        resp_ext              = '0;
        resp_ext[OUT_W-1:0]   = resp;
    end

    assign misr_next = {sig[SIG_W-2:0], 1'b0}
                     ^ (sig[SIG_W-1] ? POLY : '0)
                     ^ resp_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            stim      <= '0;
            hold_cnt  <= '0;
            sig       <= '0;
            vec_count <= '0;
            rep_flag  <= 1'b0;
        end else begin
            state     <= state_n;
            stim      <= stim_n;
            hold_cnt  <= hold_n;
            sig       <= sig_n;
            vec_count <= vc_n;
            rep_flag  <= rep_n;
        end
    end

    always_comb begin
        state_n = state;
        stim_n  = stim;
        hold_n  = hold_cnt;
        sig_n   = sig;
        vc_n    = vec_count;
        rep_n   = rep_flag;
        case (state)
            S_IDLE: begin
                if (start && run_ok) begin
                    state_n = S_APPLY;
                    stim_n  = '0;
                    hold_n  = '0;
                    sig_n   = '0;
                    vc_n    = '0;
                    rep_n   = 1'b0;
                end
            end
            S_APPLY: begin
                if (hold_cnt == HOLD_LAST) begin
                    sig_n = misr_next;
                    vc_n  = vec_count + VC_ONE;
                    // stim saturates at all ones; the optional repeat reuses it once.
                    if (stim != STIM_LAST) begin
                        stim_n = stim + STIM_ONE;
                        hold_n = '0;
                    end else if ((REPEAT_LAST != 0) && !rep_flag) begin
                        rep_n  = 1'b1;
                        hold_n = '0;
                    end else begin
                        state_n = S_FINISH;
                    end
                end else begin
                    hold_n = hold_cnt + HOLD_ONE;
                end
            end
            S_FINISH: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign busy       = (state == S_APPLY);
    assign stim_valid = (state == S_APPLY);
    assign done       = (state == S_FINISH);

endmodule

// File: tb/tb_exhaustive_stim_seq.sv
// Bench for exhaustive_stim_seq: four parameterisations share one clock and reset,
// each run is captured cycle by cycle and compared with a list-based reference.
module tb_exhaustive_stim_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic       start_a [4];
    logic [4:0] stim_a  [4];
    logic       busy_a  [4];
    logic       done_a  [4];
    logic       sv_a    [4];
    logic [15:0] sig_a  [4];
    logic [5:0] vc_a    [4];

    logic [5:0] dut_tab [32];
    logic       zero_mode = 1'b0;

    // default instance: random DUT table as response
    logic [4:0]  stim_d;
    logic [5:0]  resp_d, vc_d;
    logic [15:0] sig_d;
    logic        sv_d, busy_d, done_d;
    assign resp_d = zero_mode ? 6'd0 : dut_tab[stim_d];

    exhaustive_stim_seq u_def (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .resp(resp_d),
        .stim(stim_d), .stim_valid(sv_d), .busy(busy_d), .done(done_d),
        .sig(sig_d), .vec_count(vc_d)
    );

    // IN_W=2, REPEAT_LAST=1, resp tied to 1
    logic [1:0]  stim_r1;
    logic [2:0]  vc_r1;
    logic [15:0] sig_r1;
    logic        sv_r1, busy_r1, done_r1;
    exhaustive_stim_seq #(.IN_W(2), .REPEAT_LAST(1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .resp(6'd1),
        .stim(stim_r1), .stim_valid(sv_r1), .busy(busy_r1), .done(done_r1),
        .sig(sig_r1), .vec_count(vc_r1)
    );

    // IN_W=2, REPEAT_LAST=0, resp tied to 1
    logic [1:0]  stim_r0;
    logic [2:0]  vc_r0;
    logic [15:0] sig_r0;
    logic        sv_r0, busy_r0, done_r0;
    exhaustive_stim_seq #(.IN_W(2), .REPEAT_LAST(0)) u_r0 (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .resp(6'd1),
        .stim(stim_r0), .stim_valid(sv_r0), .busy(busy_r0), .done(done_r0),
        .sig(sig_r0), .vec_count(vc_r0)
    );

    // IN_W=2, HOLD=3, resp = stim
    logic [1:0]  stim_h3;
    logic [2:0]  vc_h3;
    logic [15:0] sig_h3;
    logic        sv_h3, busy_h3, done_h3;
    exhaustive_stim_seq #(.IN_W(2), .HOLD(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .start(start_a[3]), .resp({4'b0000, stim_h3}),
        .stim(stim_h3), .stim_valid(sv_h3), .busy(busy_h3), .done(done_h3),
        .sig(sig_h3), .vec_count(vc_h3)
    );

    assign stim_a[0] = stim_d;             assign stim_a[1] = {3'b000, stim_r1};
    assign stim_a[2] = {3'b000, stim_r0};  assign stim_a[3] = {3'b000, stim_h3};
    assign busy_a[0] = busy_d;  assign busy_a[1] = busy_r1;  assign busy_a[2] = busy_r0;  assign busy_a[3] = busy_h3;
    assign done_a[0] = done_d;  assign done_a[1] = done_r1;  assign done_a[2] = done_r0;  assign done_a[3] = done_h3;
    assign sv_a[0]   = sv_d;    assign sv_a[1]   = sv_r1;    assign sv_a[2]   = sv_r0;    assign sv_a[3]   = sv_h3;
    assign sig_a[0]  = sig_d;   assign sig_a[1]  = sig_r1;   assign sig_a[2]  = sig_r0;   assign sig_a[3]  = sig_h3;
    assign vc_a[0]   = vc_d;    assign vc_a[1]   = {3'b000, vc_r1};
    assign vc_a[2]   = {3'b000, vc_r0};        assign vc_a[3] = {3'b000, vc_h3};

    logic [4:0] cap_q[$];
    logic [4:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Signature of a response list under the MISR rule, plain integer arithmetic.
    function automatic logic [15:0] misr_fold(input int rq[$]);
        int s = 0;
        foreach (rq[i]) begin
            s = (((s * 2) % 65536) ^ ((s >= 32768) ? 'h1021 : 0)) ^ rq[i];
        end
        return 16'(s);
    endfunction

    // Expected per-cycle stim while busy: each vector HOLD times, last one optionally again.
    task automatic build_exp(input int in_w, input int hold, input int rep);
        exp_q.delete();
        for (int v = 0; v < (1 << in_w); v++)
            for (int h = 0; h < hold; h++) exp_q.push_back(5'(v));
        if (rep != 0)
            for (int h = 0; h < hold; h++) exp_q.push_back(5'((1 << in_w) - 1));
    endtask

    task automatic run_capture(input int w, input bit keep_start, input int budget,
                               output int busy_n, output int done_n, output int done_idx,
                               output logic [15:0] sig_done, output logic [5:0] vc_done,
                               output bit sig_nonzero);
        busy_n = 0; done_n = 0; done_idx = 0; sig_nonzero = 0;
        sig_done = 16'hxxxx; vc_done = 6'hxx;
        cap_q.delete();
        @(negedge clk);
        start_a[w] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (!keep_start) start_a[w] = 1'b0;
            if (busy_a[w]) begin
                busy_n++;
                cap_q.push_back(stim_a[w]);
            end
            if (sig_a[w] != 16'd0) sig_nonzero = 1'b1;
            if (done_a[w]) begin
                done_n++;
                if (done_idx == 0) begin
                    done_idx = c;
                    sig_done = sig_a[w];
                    vc_done  = vc_a[w];
                end
                start_a[w] = 1'b0;
            end
        end
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_len"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            chk($sformatf("%s_stim%0d", tag, i), cap_q[i], exp_q[i]);
    endtask

    initial begin
        int bn, dn, di;
        logic [15:0] sd;
        logic [5:0] vd;
        bit nz;
        int rq[$];
        logic [15:0] exp_sig;
        bit saw_done;

        for (int i = 0; i < 4; i++) start_a[i] = 1'b0;
        for (int i = 0; i < 32; i++) dut_tab[i] = 6'($urandom_range(0, 63));

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_stim", stim_d, 0);   chk("rst_busy", busy_d, 0);
        chk("rst_sv", sv_d, 0);       chk("rst_done", done_d, 0);
        chk("rst_sig", sig_d, 0);     chk("rst_vc", vc_d, 0);
        chk("rst_r1_busy", busy_r1, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", busy_d, 0);

        // reset mid-run
        start_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy_before", busy_d, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_stim", stim_d, 0);   chk("mid_busy", busy_d, 0);
        chk("mid_sv", sv_d, 0);       chk("mid_done", done_d, 0);
        chk("mid_sig", sig_d, 0);     chk("mid_vc", vc_d, 0);
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done_d) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done_d || busy_d) saw_done = 1'b1;
        end
        chk("mid_no_done", saw_done, 0);

        // full default run, start held high throughout
        rq.delete();
        for (int v = 0; v < 32; v++) rq.push_back(int'(dut_tab[v]));
        rq.push_back(int'(dut_tab[31]));
        exp_sig = misr_fold(rq);
        build_exp(5, 1, 1);
        run_capture(0, 1'b1, 40, bn, dn, di, sd, vd, nz);
        chk_seq("def");
        chk("def_busy", bn, 33);   chk("def_done_n", dn, 1);
        chk("def_done_at", di, 34);
        chk("def_sig", sd, exp_sig);
        chk("def_vc", vd, 33);
        chk("def_stim_hold", stim_d, 31);
        chk("def_sig_hold", sig_d, exp_sig);
        chk("def_vc_hold", vc_d, 33);

        // second run after done gives the same signature
        run_capture(0, 1'b0, 38, bn, dn, di, sd, vd, nz);
        chk("def2_busy", bn, 33);
        chk("def2_sig", sd, exp_sig);
        chk("def2_vc", vd, 33);

        // zero response
        zero_mode = 1'b1;
        run_capture(0, 1'b0, 38, bn, dn, di, sd, vd, nz);
        chk("zero_sig_nonzero", nz, 0);
        chk("zero_done_n", dn, 1);
        chk("zero_vc", vd, 33);
        zero_mode = 1'b0;

        // constant one, REPEAT_LAST=1
        build_exp(2, 1, 1);
        run_capture(1, 1'b0, 10, bn, dn, di, sd, vd, nz);
        chk_seq("r1");
        chk("r1_busy", bn, 5);   chk("r1_done_at", di, 6);   chk("r1_done_n", dn, 1);
        chk("r1_sig", sd, 16'h001F);
        chk("r1_vc", vd, 5);

        // constant one, REPEAT_LAST=0
        build_exp(2, 1, 0);
        run_capture(2, 1'b0, 10, bn, dn, di, sd, vd, nz);
        chk_seq("r0");
        chk("r0_busy", bn, 4);   chk("r0_done_at", di, 5);
        chk("r0_sig", sd, 16'h000F);
        chk("r0_vc", vd, 4);

        // HOLD=3, resp = stim
        rq.delete();
        for (int v = 0; v < 4; v++) rq.push_back(v);
        rq.push_back(3);
        build_exp(2, 3, 1);
        run_capture(3, 1'b0, 22, bn, dn, di, sd, vd, nz);
        chk_seq("h3");
        chk("h3_busy", bn, 15);   chk("h3_done_at", di, 16);
        chk("h3_sig", sd, misr_fold(rq));
        chk("h3_vc", vd, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
